// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding,
// default operand width and the bit-counter width helper.
package serial_sub_defs;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 8;

    // Counter must index bit positions 0..w-1; never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

    localparam int DEF_CNT_W = cnt_width(DEF_WIDTH);

endpackage

// File: rtl/serial_subtractor_fs_cell.sv
// Single-bit full subtractor: diff = a ^ b ^ bin,
// bout = (~a & b) | (~(a ^ b) & bin). Purely combinational, gate level.
module fs_cell (
    output logic diff,
    output logic bout,
    input  logic a,
    input  logic b,
    input  logic bin
);

    logic axb;
    logic na;
    logic naxb;
    logic gen;
    logic prop;

    xor g_axb  (axb,  a,    b);
    xor g_diff (diff, axb,  bin);
    not g_na   (na,   a);
    not g_naxb (naxb, axb);
    and g_gen  (gen,  na,   b);
    and g_prop (prop, naxb, bin);
    or  g_bout (bout, gen,  prop);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, computed LSB first through one
// full-subtractor cell and a borrow flip-flop, one bit per clock. Operands
// are accepted and results delivered over valid/ready handshakes.
module serial_subtractor
    import serial_sub_defs::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow,
    output logic             zero
);

    localparam int               CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    // Upper WIDTH-1 result bits collected so far; the newest bit enters at
    // the MSB, so after WIDTH steps {d, sh_d} is the complete difference.
    logic [WIDTH-2:0] sh_d;
    logic             br;
    logic             sa;
    logic             sb;
    logic [CNT_W-1:0] cnt;

    logic             d;
    logic             bo;
    logic [WIDTH-1:0] res;

    fs_cell u_cell (
        .diff (d),
        .bout (bo),
        .a    (sh_a[0]),
        .b    (sh_b[0]),
        .bin  (br)
    );

    assign res       = {d, sh_d};
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Handshake FSM, operand/result shifting, borrow FF and result flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sh_a       <= '0;
            sh_b       <= '0;
            sh_d       <= '0;
            br         <= 1'b0;
            sa         <= 1'b0;
            sb         <= 1'b0;
            cnt        <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
            overflow   <= 1'b0;
            zero       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sh_a  <= a;
                        sh_b  <= b;
                        sh_d  <= '0;
                        br    <= bin;
                        sa    <= a[WIDTH-1];
                        sb    <= b[WIDTH-1];
                        cnt   <= '0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    sh_d <= res[WIDTH-1:1];
                    sh_a <= sh_a >> 1;
                    sh_b <= sh_b >> 1;
                    br   <= bo;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        diff       <= res;
                        borrow_out <= bo;
                        // Signed overflow: operand signs differ and the
                        // result sign disagrees with the minuend.
                        overflow   <= (sa != sb) && (d != sa);
                        zero       <= (res == '0);
                        state      <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: the driver pushes the reference
// result of every accepted operation into a queue, the monitor pops and
// compares on each output handshake and checks completion latency.
module tb_serial_subtractor;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] diff;
        logic         bo;
        logic         ov;
        logic         z;
        int           acc;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic         bin_i;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         borrow_out;
    logic         overflow;
    logic         zero;

    logic         rr_mode;
    logic         rr;
    logic         man_ready;

    int           cyc;
    int           nvec;
    int           nerr;
    int           ncmp;
    exp_t         sb[$];

    assign out_ready = rr_mode ? rr : man_ready;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a_i),
        .b          (b_i),
        .bin        (bin_i),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .diff       (diff),
        .borrow_out (borrow_out),
        .overflow   (overflow),
        .zero       (zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc <= cyc + 1;
        end
    end

    initial begin
        rr = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rr = 1'($urandom_range(0, 1));
        end
    end

    // Reference: plain integer arithmetic on the operands.
    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                   input logic bv_in, input int acc);
        exp_t   e;
        longint ua;
        longint ub;
        longint r;
        ua     = longint'(av);
        ub     = longint'(bv);
        r      = ua - ub - longint'(bv_in);
        e.diff = W'(r);
        e.bo   = (r < 0);
        e.ov   = (av[W-1] != bv[W-1]) && (e.diff[W-1] != av[W-1]);
        e.z    = (e.diff == '0);
        e.acc  = acc;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: latency on the rising edge of out_valid, full compare on handshake.
    initial begin
        logic ov_prev;
        exp_t e;
        ov_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                ov_prev = 1'b0;
            end else begin
                if (out_valid && !ov_prev) begin
                    if (sb.size() == 0) begin
                        nerr++;
                        $display("FAIL unexpected_out_valid: got 1 expected 0 (t=%0t)", $time);
                    end else begin
                        chk("latency", 32'(cyc - sb[0].acc), 32'(W));
                    end
                end
                if (out_valid && out_ready && sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("diff",       32'(diff),       32'(e.diff));
                    chk("borrow_out", 32'(borrow_out), 32'(e.bo));
                    chk("overflow",   32'(overflow),   32'(e.ov));
                    chk("zero",       32'(zero),       32'(e.z));
                end
                ov_prev = out_valid;
            end
        end
    end

    task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bv_in);
        int t;
        t        = 0;
        a_i      = av;
        b_i      = bv;
        bin_i    = bv_in;
        in_valid = 1'b1;
        while (!in_ready && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!in_ready) begin
            nerr++;
            $display("FAIL accept_timeout: got in_ready 0 expected 1");
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            sb.push_back(model(av, bv, bv_in, cyc));
            nvec++;
            in_valid = 1'b0;
            a_i      = W'($urandom);
            b_i      = W'($urandom);
            bin_i    = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (sb.size() != 0) begin
            nerr++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        exp_t e;
        int   t;
        nvec      = 0;
        nerr      = 0;
        ncmp      = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a_i       = '0;
        b_i       = '0;
        bin_i     = 1'b0;
        man_ready = 1'b1;
        rr_mode   = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready",   32'(in_ready),   32'd1);
        chk("rst_out_valid",  32'(out_valid),  32'd0);
        chk("rst_diff",       32'(diff),       32'd0);
        chk("rst_borrow_out", 32'(borrow_out), 32'd0);
        chk("rst_overflow",   32'(overflow),   32'd0);
        chk("rst_zero",       32'(zero),       32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed arithmetic cases
        send(8'h05, 8'h03, 1'b0);
        send(8'h03, 8'h05, 1'b0);
        send(8'h80, 8'h01, 1'b0);
        send(8'h7F, 8'hFF, 1'b0);
        send(8'h00, 8'hFF, 1'b1);
        send(8'h10, 8'h0F, 1'b1);
        drain();

        // Backpressure: result must hold while out_ready stays low
        man_ready = 1'b0;
        send(8'hA7, 8'h39, 1'b1);
        e = sb[0];
        t = 0;
        while (!out_valid && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("bp_reach_done", 32'(out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            a_i      = W'($urandom);
            b_i      = W'($urandom);
            bin_i    = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            chk("bp_out_valid", 32'(out_valid),  32'd1);
            chk("bp_in_ready",  32'(in_ready),   32'd0);
            chk("bp_diff",      32'(diff),       32'(e.diff));
            chk("bp_borrow",    32'(borrow_out), 32'(e.bo));
            chk("bp_overflow",  32'(overflow),   32'(e.ov));
            chk("bp_zero",      32'(zero),       32'(e.z));
        end
        in_valid  = 1'b0;
        man_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_out_valid", 32'(out_valid), 32'd0);
        chk("bp_release_in_ready",  32'(in_ready),  32'd1);
        send(8'h3C, 8'h4D, 1'b1);
        drain();

        // Randomized operands with random consumer backpressure
        rr_mode = 1'b1;
        for (int i = 0; i < 40; i++) begin
            send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
        end
        drain();
        rr_mode = 1'b0;

        // Asynchronous reset in the middle of an operation
        send(8'h5A, 8'h33, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("mid_rst_in_ready",   32'(in_ready),   32'd1);
        chk("mid_rst_out_valid",  32'(out_valid),  32'd0);
        chk("mid_rst_diff",       32'(diff),       32'd0);
        chk("mid_rst_borrow_out", 32'(borrow_out), 32'd0);
        chk("mid_rst_overflow",   32'(overflow),   32'd0);
        chk("mid_rst_zero",       32'(zero),       32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (W + 2) @(posedge clk);
        #1;
        chk("post_rst_no_result", 32'(out_valid), 32'd0);
        send(8'h05, 8'h03, 1'b0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
